load_store_unit: RTL and testbench

- MEM-stage requester for the data-memory controller interface (write_En/read_En/func3/address/data_in in, data_out/ready back).
- Accepts one load or store per instruction from the pipeline and holds the pipeline with a stall while the controller is busy.
- Performs alignment checks, store-lane replication and load byte/half extraction with sign or zero extension.
- Bounds every access with a timeout.

---
 rtl/load_store_unit.sv | 170 +++++++++++++++++
 tb/tb_load_store_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// MEM-stage load/store requester: validates each access, drives the data-memory
// controller handshake, extracts/extends load data and aborts accesses that time out.
module load_store_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int FUNC3_WIDTH    = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     memRead,
  input  logic                     memWrite,
  input  logic [FUNC3_WIDTH-1:0]   func3,
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0]    storeData,
  output logic [DATA_WIDTH-1:0]    loadData,
  output logic                     stall,
  output logic                     done,
  output logic                     misalignErr,
  output logic                     busErr,
  output logic                     write_En,
  output logic                     read_En,
  output logic [FUNC3_WIDTH-1:0]   func3_out,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]    mem_data,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  input  logic                     mem_ready
);

  localparam int CountWidth = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e                   state_q;
  logic [CountWidth-1:0]    count_q;
  logic                     readEn_q, writeEn_q, done_q, busErr_q, misalignErr_q;
  logic [FUNC3_WIDTH-1:0]   func3_q;
  logic [ADDRESS_WIDTH-1:0] address_q;
  logic [DATA_WIDTH-1:0]    memData_q, loadData_q;

  logic [DATA_WIDTH-1:0]    storeLanes_d, loadResult_d;
  logic                     funcLegal, aligned, reqValid, reqIllegal;
  logic [7:0]               loadByte;
  logic [15:0]              loadHalf;

  // A request is legal only when exactly one of read/write is set and size/alignment fit.
  always_comb begin
    funcLegal = 1'b0;
    if (memRead) begin
      case (func3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: funcLegal = 1'b1;
        default: funcLegal = 1'b0;
      endcase
    end else begin
      case (func3)
        3'b000, 3'b001, 3'b010: funcLegal = 1'b1;
        default: funcLegal = 1'b0;
      endcase
    end
    aligned = 1'b1;
    case (func3[1:0])
      2'b01:   aligned = ~address[0];
      2'b10:   aligned = (address[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    reqValid   = (memRead ^ memWrite) & funcLegal & aligned;
    reqIllegal = (memRead | memWrite) & ~reqValid;
  end

  always_comb begin
    case (func3[1:0])
      2'b00:   storeLanes_d = {4{storeData[7:0]}};
      2'b01:   storeLanes_d = {2{storeData[15:0]}};
      default: storeLanes_d = storeData;
    endcase
  end

  // Extraction uses the latched address/func3, since the pipeline inputs may not be trusted here.
  always_comb begin
    case (address_q[1:0])
      2'b00:   loadByte = mem_rdata[7:0];
      2'b01:   loadByte = mem_rdata[15:8];
      2'b10:   loadByte = mem_rdata[23:16];
      default: loadByte = mem_rdata[31:24];
    endcase
    loadHalf = address_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (func3_q)
      3'b000:  loadResult_d = {{(DATA_WIDTH-8){loadByte[7]}}, loadByte};
      3'b001:  loadResult_d = {{(DATA_WIDTH-16){loadHalf[15]}}, loadHalf};
      3'b100:  loadResult_d = {{(DATA_WIDTH-8){1'b0}}, loadByte};
      3'b101:  loadResult_d = {{(DATA_WIDTH-16){1'b0}}, loadHalf};
      default: loadResult_d = mem_rdata;
    endcase
  end

  assign stall = ((state_q == IDLE) && reqValid) || (state_q == BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      count_q       <= '0;
      readEn_q      <= 1'b0;
      writeEn_q     <= 1'b0;
      done_q        <= 1'b0;
      busErr_q      <= 1'b0;
      misalignErr_q <= 1'b0;
      func3_q       <= '0;
      address_q     <= '0;
      memData_q     <= '0;
      loadData_q    <= '0;
    end else begin
      misalignErr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          done_q     <= 1'b0;
          busErr_q   <= 1'b0;
          loadData_q <= '0;
          count_q    <= '0;
          if (reqValid) begin
            readEn_q  <= memRead;
            writeEn_q <= memWrite;
            func3_q   <= func3;
            address_q <= address;
            memData_q <= storeLanes_d;
            state_q   <= BUSY;
          end else begin
            misalignErr_q <= reqIllegal;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            readEn_q   <= 1'b0;
            writeEn_q  <= 1'b0;
            loadData_q <= readEn_q ? loadResult_d : '0;
            done_q     <= 1'b1;
            state_q    <= DONE;
          end else if (count_q == CountWidth'(TIMEOUT_CYCLES - 1)) begin
            readEn_q   <= 1'b0;
            writeEn_q  <= 1'b0;
            loadData_q <= '0;
            busErr_q   <= 1'b1;
            done_q     <= 1'b1;
            state_q    <= DONE;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        DONE: begin
          done_q     <= 1'b0;
          busErr_q   <= 1'b0;
          loadData_q <= '0;
          count_q    <= '0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign loadData    = loadData_q;
  assign done        = done_q;
  assign busErr      = busErr_q;
  assign misalignErr = misalignErr_q;
  assign read_En     = readEn_q;
  assign write_En    = writeEn_q;
  assign func3_out   = func3_q;
  assign mem_address = address_q;
  assign mem_data    = memData_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: a transaction-level model predicts every
// output cycle by cycle, with a few directed accesses pinned to literal results.
module tb_load_store_unit;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        memRead, memWrite, mem_ready;
  logic [2:0]  func3;
  logic [31:0] address, storeData, mem_rdata;
  logic [31:0] loadData, mem_address, mem_data;
  logic [2:0]  func3_out;
  logic        stall, done, misalignErr, busErr, write_En, read_En;

  load_store_unit #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .FUNC3_WIDTH(3), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .memRead(memRead), .memWrite(memWrite), .func3(func3),
    .address(address), .storeData(storeData), .loadData(loadData), .stall(stall),
    .done(done), .misalignErr(misalignErr), .busErr(busErr), .write_En(write_En),
    .read_En(read_En), .func3_out(func3_out), .mem_address(mem_address),
    .mem_data(mem_data), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          fails = 0;
  logic        chkEn = 1'b0;
  logic        expStall, expDone, expBus, expMis, expRd, expWr;
  logic        chkLoad, chkReq, litEn, litOnData;
  logic [31:0] expLoad, expAddr, expData, litVal;
  logic [2:0]  expF3;
  logic        prevIllegal = 1'b0;

  function automatic logic refLegal(input logic rd, input logic wr, input logic [2:0] f3,
                                    input logic [31:0] addr);
    int size;
    logic f3Ok;
    size = 1 << f3[1:0];
    f3Ok = rd ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
    return (rd != wr) && f3Ok && ((addr % size) == 0);
  endfunction

  function automatic logic [31:0] refStore(input logic [2:0] f3, input logic [31:0] sd);
    logic [31:0] b, h;
    b = sd & 32'hFF;
    h = sd & 32'hFFFF;
    if (f3[1:0] == 2'd0) return b * 32'h01010101;
    if (f3[1:0] == 2'd1) return h * 32'h00010001;
    return sd;
  endfunction

  function automatic logic [31:0] refLoad(input logic [2:0] f3, input logic [31:0] w,
                                          input logic [1:0] a);
    logic [31:0] shB, shH;
    logic [7:0]  b;
    logic [15:0] h;
    shB = w >> (8 * a);
    shH = w >> (16 * a[1]);
    b = shB[7:0];
    h = shH[15:0];
    case (f3)
      3'd0: return 32'($signed(b));
      3'd1: return 32'($signed(h));
      3'd4: return 32'(b);
      3'd5: return 32'(h);
      default: return w;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chkEn) begin
      checkOutput("stall", 32'(stall), 32'(expStall));
      checkOutput("done", 32'(done), 32'(expDone));
      checkOutput("busErr", 32'(busErr), 32'(expBus));
      checkOutput("misalignErr", 32'(misalignErr), 32'(expMis));
      checkOutput("read_En", 32'(read_En), 32'(expRd));
      checkOutput("write_En", 32'(write_En), 32'(expWr));
      if (chkLoad) checkOutput("loadData", loadData, expLoad);
      if (chkReq) begin
        checkOutput("mem_address", mem_address, expAddr);
        checkOutput("func3_out", 32'(func3_out), 32'(expF3));
        if (expWr) checkOutput("mem_data", mem_data, expData);
      end
      if (litEn) checkOutput("literal", litOnData ? mem_data : loadData, litVal);
    end
  end

  task automatic clearExp();
    expStall = 1'b0; expDone = 1'b0; expBus = 1'b0; expMis = 1'b0;
    expRd = 1'b0; expWr = 1'b0; chkLoad = 1'b1; expLoad = '0;
    chkReq = 1'b0; litEn = 1'b0; litOnData = 1'b0;
  endtask

  task automatic idleCycle();
    @(posedge clk); #1;
    memRead = 1'b0; memWrite = 1'b0;
    func3 = 3'($urandom); address = $urandom; mem_ready = 1'($urandom);
    mem_rdata = $urandom;
    clearExp();
    expMis = prevIllegal;
    prevIllegal = 1'b0;
  endtask

  // One instruction: issue cycle, then (if legal) its BUSY cycles and the DONE cycle.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] sd,
                               input logic [31:0] rdat, input int k,
                               input logic useLit, input logic [31:0] lit);
    logic legal, timeout;
    int   busy;
    @(posedge clk); #1;
    memRead = rd; memWrite = wr; func3 = f3; address = addr; storeData = sd;
    mem_rdata = $urandom; mem_ready = 1'($urandom);
    legal = refLegal(rd, wr, f3, addr);
    clearExp();
    expMis = prevIllegal;
    expStall = legal;
    prevIllegal = (rd | wr) & ~legal;
    if (legal) begin
      timeout = (k > T);
      busy = timeout ? T : k;
      for (int c = 1; c <= busy; c++) begin
        @(posedge clk); #1;
        mem_ready = (c == k);
        mem_rdata = (c == k) ? rdat : $urandom;
        clearExp();
        expStall = 1'b1; expRd = rd; expWr = wr;
        chkReq = 1'b1; expAddr = addr; expF3 = f3; expData = refStore(f3, sd);
        litEn = useLit & wr; litOnData = 1'b1; litVal = lit;
      end
      @(posedge clk); #1;
      mem_ready = 1'($urandom); mem_rdata = $urandom;
      clearExp();
      expDone = 1'b1;
      expBus = timeout;
      if (wr && !timeout) chkLoad = 1'b0;
      else expLoad = timeout ? 32'h0 : refLoad(f3, rdat, addr[1:0]);
      litEn = useLit & rd; litOnData = 1'b0; litVal = lit;
    end
  endtask

  initial begin
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    int          r;
    rst = 1'b1; memRead = 1'b0; memWrite = 1'b0; func3 = '0; address = '0;
    storeData = '0; mem_rdata = '0; mem_ready = 1'b0;
    clearExp();
    repeat (2) @(posedge clk);
    #1;
    chkEn = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    applyStimulus(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 1, 1'b1, 32'hFFFFFF80);
    applyStimulus(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h8001ABCD, 1, 1'b1, 32'h00008001);
    applyStimulus(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h8001ABCD, 2, 1'b1, 32'hFFFF8001);
    applyStimulus(1'b0, 1'b1, 3'b000, 32'h41, 32'h123456AB, 32'h0, 3, 1'b1, 32'hABABABAB);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h6, 32'h0, 32'h0, 1, 1'b0, 32'h0);
    idleCycle();
    applyStimulus(1'b1, 1'b1, 3'b010, 32'h8, 32'h0, 32'h0, 1, 1'b0, 32'h0);
    idleCycle();
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 32'h11111111, T + 1, 1'b1, 32'h0);

    // Reset lands in the middle of a BUSY load.
    @(posedge clk); #1;
    memRead = 1'b1; memWrite = 1'b0; func3 = 3'b010; address = 32'h10; mem_ready = 1'b0;
    clearExp(); expMis = prevIllegal; prevIllegal = 1'b0; expStall = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      mem_ready = 1'b0;
      clearExp(); expStall = 1'b1; expRd = 1'b1;
      chkReq = 1'b1; expAddr = 32'h10; expF3 = 3'b010;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; memRead = 1'b0;
    clearExp();
    idleCycle();
    idleCycle();
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 2, 1'b1, 32'hCAFEF00D);

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      rd = (r <= 5);
      wr = (r == 0) || (r > 5);
      f3 = ($urandom_range(0, 1) == 0) ? 3'($urandom) : (rd ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 2)));
      if (rd && $urandom_range(0, 2) == 0) f3 = 3'(4 + $urandom_range(0, 1));
      addr = $urandom;
      if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
      applyStimulus(rd, wr, f3, addr, $urandom, $urandom, $urandom_range(1, T + 2), 1'b0, 32'h0);
      repeat ($urandom_range(0, 2)) idleCycle();
    end

    idleCycle();
    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
